// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip memory.
// Each accepted command costs one IDLE and one ISSUE cycle; reads return one cycle after ISSUE.
module onchip_mem_arbiter #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 32,
   parameter int NUM_WORDS = 25000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   input  logic [DATA_W-1:0]     mem_readdata,
   output logic [15:0]           err_count,
   output logic                  dbg_state_o
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_WORDS);

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

   state_t              state_q;
   logic                grant_q;
   logic                last_grant_q;
   logic [1:0]          wait_q;
   logic [1:0]          rdv_q;
   logic                rd_q;
   logic                rd_ok_q;
   logic                oor_q;
   logic [ADDR_W-1:0]   mem_address_q;
   logic [BE_W-1:0]     mem_be_q;
   logic [DATA_W-1:0]   mem_wd_q;
   logic                mem_cs_q;
   logic                mem_we_q;
   logic [15:0]         err_q;

   logic                req0, req1, win, win_rd, win_wr, win_in_range;
   logic [ADDR_W-1:0]   win_addr;
   logic [BE_W-1:0]     win_be;
   logic [DATA_W-1:0]   win_wd;

   // A tie goes to the master that was not granted last; a lone requester always wins.
   always_comb begin
      req0         = m0_read | m0_write;
      req1         = m1_read | m1_write;
      win          = (req0 && req1) ? ~last_grant_q : req1;
      win_addr     = win ? m1_address    : m0_address;
      win_be       = win ? m1_byteenable : m0_byteenable;
      win_wd       = win ? m1_writedata  : m0_writedata;
      win_rd       = win ? m1_read       : m0_read;
      win_wr       = win ? m1_write      : m0_write;
      win_in_range = ({1'b0, win_addr} < LIMIT);
   end

   // Handshake: a master holds read/write until it sees waitrequest low; the command is
   // accepted on the rising edge that ends that cycle, so the master drops it right after.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         grant_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         wait_q        <= 2'b11;
         rdv_q         <= 2'b00;
         rd_q          <= 1'b0;
         rd_ok_q       <= 1'b0;
         oor_q         <= 1'b0;
         mem_address_q <= '0;
         mem_be_q      <= '0;
         mem_wd_q      <= '0;
         mem_cs_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         err_q         <= 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               rdv_q <= 2'b00;
               if (req0 || req1) begin
                  state_q       <= ISSUE;
                  grant_q       <= win;
                  wait_q        <= win ? 2'b01 : 2'b10;
                  mem_address_q <= win_addr;
                  mem_be_q      <= win_be;
                  mem_wd_q      <= win_wd;
                  mem_cs_q      <= win_in_range;
                  mem_we_q      <= win_in_range & win_wr;
                  rd_q          <= win_rd & ~win_wr;
                  oor_q         <= ~win_in_range;
               end
            end
            ISSUE: begin
               state_q       <= IDLE;
               last_grant_q  <= grant_q;
               wait_q        <= 2'b11;
               rdv_q         <= grant_q ? {rd_q, 1'b0} : {1'b0, rd_q};
               rd_ok_q       <= ~oor_q;
               mem_address_q <= '0;
               mem_be_q      <= '0;
               mem_wd_q      <= '0;
               mem_cs_q      <= 1'b0;
               mem_we_q      <= 1'b0;
               rd_q          <= 1'b0;
               oor_q         <= 1'b0;
               if (oor_q && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Reset masks the strobes immediately so an in-flight ISSUE can neither commit nor return.
   assign m0_waitrequest   = wait_q[0] | reset;
   assign m1_waitrequest   = wait_q[1] | reset;
   assign m0_readdatavalid = rdv_q[0] & ~reset;
   assign m1_readdatavalid = rdv_q[1] & ~reset;
   assign m0_readdata      = (m0_readdatavalid && rd_ok_q) ? mem_readdata : '0;
   assign m1_readdata      = (m1_readdatavalid && rd_ok_q) ? mem_readdata : '0;
   assign mem_address      = mem_address_q;
   assign mem_byteenable   = mem_be_q;
   assign mem_writedata    = mem_wd_q;
   assign mem_chipselect   = mem_cs_q & ~reset;
   assign mem_write        = mem_we_q & ~reset;
   assign err_count        = err_q;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural memory, reference word map and read-return scoreboard.
module tb_onchip_mem_arbiter;
  localparam int ADDR_W    = 15;
  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 25000;
  localparam int BE_W      = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [ADDR_W-1:0] m_addr [2];
  logic [BE_W-1:0]   m_be   [2];
  logic              m_rd   [2];
  logic              m_wr   [2];
  logic [DATA_W-1:0] m_wd   [2];
  logic              m_wait [2];
  logic [DATA_W-1:0] m_rdata[2];
  logic              m_rdv  [2];

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic [15:0]       err_count;
  logic              dbg_state;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m_addr[0]),
    .m0_byteenable    (m_be[0]),
    .m0_read          (m_rd[0]),
    .m0_write         (m_wr[0]),
    .m0_writedata     (m_wd[0]),
    .m0_waitrequest   (m_wait[0]),
    .m0_readdata      (m_rdata[0]),
    .m0_readdatavalid (m_rdv[0]),
    .m1_address       (m_addr[1]),
    .m1_byteenable    (m_be[1]),
    .m1_read          (m_rd[1]),
    .m1_write         (m_wr[1]),
    .m1_writedata     (m_wd[1]),
    .m1_waitrequest   (m_wait[1]),
    .m1_readdata      (m_rdata[1]),
    .m1_readdatavalid (m_rdv[1]),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_readdata     (mem_readdata),
    .err_count        (err_count),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- physical memory behind the arbiter ----------------
  logic [DATA_W-1:0] mem [NUM_WORDS];
  initial for (int i = 0; i < NUM_WORDS; i++) mem[i] = '0;

  // Unselected cycles return garbage so any leak into readdata is visible.
  always @(posedge clk) begin
    if (mem_chipselect && int'(mem_address) < NUM_WORDS) begin
      mem_readdata <= mem[mem_address];
      if (mem_write)
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end else begin
      mem_readdata <= $urandom;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] ref_mem [int];
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  int                exp_c0[$];
  int                exp_c1[$];
  int                grant_log[$];
  int                grant_cyc[$];
  logic [DATA_W-1:0] last_rd [2];
  int                exp_err = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DATA_W-1:0] ref_read(input int a);
    if (a >= NUM_WORDS) return '0;
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic void ref_write(input int a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] w;
    w = ref_read(a);
    for (int b = 0; b < BE_W; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
    ref_mem[a] = w;
  endfunction

  // Monitor: every read return is matched against the queue of the master that issued it.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (m_rdv[m]) begin
        if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdv m%0d: got readdatavalid=1 expected 0 (t=%0t)", m, $time);
        end else begin
          logic [DATA_W-1:0] ed;
          int ec;
          if (m == 0) begin ed = exp_q0.pop_front(); ec = exp_c0.pop_front(); end
          else        begin ed = exp_q1.pop_front(); ec = exp_c1.pop_front(); end
          check($sformatf("readdata_m%0d", m), m_rdata[m], ed);
          check($sformatf("rdv_latency_m%0d", m), cyc, ec + 1);
          last_rd[m] = m_rdata[m];
        end
      end else begin
        check($sformatf("readdata_idle_zero_m%0d", m), m_rdata[m], '0);
      end
    end
    if (!m_wait[0] && !m_wait[1]) check("single_grant", 1, 0);
    if (m_wait[0] && m_wait[1])
      check("mem_idle_zero",
            {mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata}, '0);
    if (mem_chipselect) check("cs_in_range", int'(mem_address) < NUM_WORDS, 1);
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issues one command from master m and holds it until accepted (bounded).
  task automatic do_op(input int m, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    bit done;
    bit inr;
    done = 0;
    inr  = int'(a) < NUM_WORDS;
    m_addr[m] = a; m_wd[m] = d; m_be[m] = be; m_rd[m] = rd; m_wr[m] = wr;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!m_wait[m]) begin
        done = 1;
        check($sformatf("accept_cs_m%0d", m), mem_chipselect, inr);
        check($sformatf("accept_we_m%0d", m), mem_write, inr && wr);
        check($sformatf("accept_addr_m%0d", m), mem_address, a);
        if (wr) begin
          check($sformatf("accept_wd_m%0d", m), mem_writedata, d);
          check($sformatf("accept_be_m%0d", m), mem_byteenable, be);
        end
        check($sformatf("other_wait_m%0d", m), m_wait[1-m], 1);
        if (wr) begin
          if (inr) ref_write(int'(a), d, be);
        end else if (rd) begin
          if (m == 0) begin exp_q0.push_back(ref_read(int'(a))); exp_c0.push_back(cyc); end
          else        begin exp_q1.push_back(ref_read(int'(a))); exp_c1.push_back(cyc); end
        end
        if (!inr && exp_err < 16'hFFFF) exp_err++;
        grant_log.push_back(m);
        grant_cyc.push_back(cyc);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout m%0d: got no accept expected accept within 64 cycles", m);
    end
    @(posedge clk);
    #1;
    m_rd[m] = 1'b0; m_wr[m] = 1'b0; m_addr[m] = '0; m_wd[m] = '0; m_be[m] = '0;
    if (done) check($sformatf("wait_one_cycle_m%0d", m), m_wait[m], 1);
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0, 1, 2, 3: return ADDR_W'($urandom_range(0, 15));
      4:          return ADDR_W'(NUM_WORDS - 2 + $urandom_range(0, 3));
      default:    return ADDR_W'($urandom_range(NUM_WORDS, (1 << ADDR_W) - 1));
    endcase
  endfunction

  task automatic random_master(input int m, input int n);
    for (int k = 0; k < n; k++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_op(m, kind != 1, kind != 0, pick_addr(), $urandom, BE_W'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_err = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    for (int m = 0; m < 2; m++) begin
      m_addr[m] = '0; m_be[m] = '0; m_rd[m] = 1'b0; m_wr[m] = 1'b0; m_wd[m] = '0;
      last_rd[m] = '1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait0", m_wait[0], 1);
    check("rst_wait1", m_wait[1], 1);
    check("rst_rdv0", m_rdv[0], 0);
    check("rst_rdv1", m_rdv[1], 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_err", err_count, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // write then read back on m0
    do_op(0, 0, 1, 15'h0010, 32'hA5A5A5A5, 4'hF);
    do_op(0, 1, 0, 15'h0010, '0, '0);
    wait_cycles(3);
    check("rw_m0_data", last_rd[0], 32'hA5A5A5A5);

    // read+write together is a write
    do_op(0, 1, 1, 15'h0020, 32'h5, 4'hF);
    do_op(0, 1, 0, 15'h0020, '0, '0);
    wait_cycles(3);
    check("rdwr_is_write", last_rd[0], 32'h00000005);

    // partial byte lanes over zeros
    do_op(1, 0, 1, 15'h1234, 32'h11223344, 4'h3);
    do_op(1, 1, 0, 15'h1234, '0, '0);
    wait_cycles(3);
    check("partial_be", last_rd[1], 32'h00003344);

    // out-of-range write and read
    last_rd[0] = '1;
    do_op(0, 0, 1, 15'h61A8, 32'hDEADBEEF, 4'hF);
    do_op(0, 1, 0, 15'h61A8, '0, '0);
    wait_cycles(3);
    check("oor_readdata", last_rd[0], 0);
    check("oor_err_count", err_count, 16'd2);

    // both masters reading continuously alternate, starting with m0 after reset
    apply_reset(2);
    grant_log.delete();
    grant_cyc.delete();
    fork
      repeat (6) do_op(0, 1, 0, ADDR_W'($urandom_range(0, 15)), '0, '0);
      repeat (6) do_op(1, 1, 0, ADDR_W'($urandom_range(0, 15)), '0, '0);
    join
    wait_cycles(3);
    check("rr_count", grant_log.size(), 12);
    for (int i = 0; i < grant_log.size(); i++) begin
      check($sformatf("rr_order_%0d", i), grant_log[i], i % 2);
      if (i > 0) check($sformatf("rr_spacing_%0d", i), grant_cyc[i] - grant_cyc[i-1], 2);
    end

    // reset during ISSUE of a read aborts it
    m_addr[0] = 15'h0005; m_rd[0] = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (!m_wait[0]) seen = 1;
      end
      check("rst_issue_reached", seen, 1);
    end
    #2;
    reset = 1'b1;
    #1;
    check("rst_issue_wait", m_wait[0], 1);
    check("rst_issue_cs", mem_chipselect, 0);
    @(posedge clk);
    #1;
    m_rd[0] = 1'b0; m_addr[0] = '0;
    @(negedge clk);
    check("rst_issue_no_rdv", m_rdv[0], 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_err = 0;
    check("rst_issue_err", err_count, 0);
    grant_log.delete();
    grant_cyc.delete();
    fork
      do_op(0, 1, 0, 15'h0003, '0, '0);
      do_op(1, 1, 0, 15'h0004, '0, '0);
    join
    check("rst_first_tie_m0", grant_log[0], 0);

    // randomized traffic from both masters
    fork
      random_master(0, 40);
      random_master(1, 40);
    join
    wait_cycles(4);
    check("final_err_count", err_count, exp_err);
    check("final_q0_empty", exp_q0.size(), 0);
    check("final_q1_empty", exp_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
